// File: rtl/score_keeper_if.sv
// Bundles the score keeper's game inputs and display/score outputs.
interface score_keeper_if;
  logic       miss_left;
  logic       miss_right;
  logic       vblank;
  logic       new_game;
  logic [3:0] score_left;
  logic [3:0] score_right;
  logic       serve;
  logic       serve_dir;
  logic       game_over;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output miss_left, miss_right, vblank, new_game,
    input  score_left, score_right, serve, serve_dir, game_over, an, seg, dp
  );

  modport slave (
    input  miss_left, miss_right, vblank, new_game,
    output score_left, score_right, serve, serve_dir, game_over, an, seg, dp
  );
endinterface

// File: rtl/score_keeper.sv
// Pong score keeper: serve timing, point scoring, game-over detection and a
// four-digit multiplexed seven-segment score display.
module score_keeper #(
  parameter int unsigned WIN_SCORE   = 9,
  parameter int unsigned SERVE_DELAY = 120,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input logic           clk,
  input logic           rst_n,
  score_keeper_if.slave bus
);
  localparam int unsigned SCORE_W = 4;
  localparam int unsigned FRAME_W = 8;
  localparam int unsigned REF_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);
  localparam logic [FRAME_W-1:0] DELAY    = FRAME_W'(SERVE_DELAY);
  localparam logic [REF_W-1:0]   REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [6:0]         SEG_DASH = 7'b0111111;

  typedef enum logic [1:0] {ST_SERVE, ST_PLAY, ST_GAME_OVER} state_e;

  logic miss_l_q, miss_r_q, vblank_q, new_game_q, armed_q;
  logic miss_l_rise, miss_r_rise, vblank_rise, new_game_rise;

  state_e               state_q, state_d;
  logic [FRAME_W-1:0]   frame_q, frame_d, frame_inc;
  logic [SCORE_W-1:0]   score_l_q, score_l_d, score_l_inc;
  logic [SCORE_W-1:0]   score_r_q, score_r_d, score_r_inc;
  logic                 serve_q, serve_d, dir_q, dir_d, over_q, over_d;
  logic [REF_W-1:0]     ref_q, ref_d;
  logic [1:0]           digit_q, digit_d;
  logic [3:0]           an_q, an_d;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // armed_q masks the first cycle after reset so inputs already high at release are not edges
  assign miss_l_rise   = armed_q & bus.miss_left  & ~miss_l_q;
  assign miss_r_rise   = armed_q & bus.miss_right & ~miss_r_q;
  assign vblank_rise   = armed_q & bus.vblank     & ~vblank_q;
  assign new_game_rise = armed_q & bus.new_game   & ~new_game_q;

  assign frame_inc   = FRAME_W'(frame_q + FRAME_W'(1));
  assign score_l_inc = (score_l_q < WIN) ? SCORE_W'(score_l_q + SCORE_W'(1)) : score_l_q;
  assign score_r_inc = (score_r_q < WIN) ? SCORE_W'(score_r_q + SCORE_W'(1)) : score_r_q;

  // Game FSM next state, scores and serve control
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    serve_d   = 1'b0;
    dir_d     = dir_q;
    if (new_game_rise) begin
      state_d   = ST_SERVE;
      frame_d   = '0;
      score_l_d = '0;
      score_r_d = '0;
      dir_d     = 1'b0;
    end else begin
      unique case (state_q)
        ST_SERVE: begin
          if (vblank_rise) begin
            frame_d = frame_inc;
            if (frame_inc == DELAY) begin
              serve_d = 1'b1;
              state_d = ST_PLAY;
              frame_d = '0;
            end
          end
        end
        ST_PLAY: begin
          if (miss_l_rise && miss_r_rise) begin
            state_d = ST_SERVE;
          end else if (miss_l_rise) begin
            score_r_d = score_r_inc;
            dir_d     = 1'b0;
            state_d   = (score_r_inc == WIN) ? ST_GAME_OVER : ST_SERVE;
          end else if (miss_r_rise) begin
            score_l_d = score_l_inc;
            dir_d     = 1'b1;
            state_d   = (score_l_inc == WIN) ? ST_GAME_OVER : ST_SERVE;
          end
        end
        ST_GAME_OVER: state_d = ST_GAME_OVER;
        default:      state_d = ST_SERVE;
      endcase
    end
    over_d = (state_d == ST_GAME_OVER);
  end

  // Display scan; built from next-state values so an, seg and dp move together
  always_comb begin
    ref_d   = (ref_q == REF_LAST) ? '0 : REF_W'(ref_q + REF_W'(1));
    digit_d = (ref_q == REF_LAST) ? 2'(digit_q + 2'd1) : digit_q;
    an_d    = ~(4'b0001 << digit_d);
    unique case (digit_d)
      2'd0:    seg_d = seg_decode(score_r_d);
      2'd3:    seg_d = seg_decode(score_l_d);
      default: seg_d = SEG_DASH;
    endcase
    dp_d = 1'b1;
    if (over_d && digit_d == 2'd3 && score_l_d == WIN) dp_d = 1'b0;
    if (over_d && digit_d == 2'd0 && score_r_d == WIN) dp_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_l_q   <= 1'b0;
      miss_r_q   <= 1'b0;
      vblank_q   <= 1'b0;
      new_game_q <= 1'b0;
      armed_q    <= 1'b0;
      state_q    <= ST_SERVE;
      frame_q    <= '0;
      score_l_q  <= '0;
      score_r_q  <= '0;
      serve_q    <= 1'b0;
      dir_q      <= 1'b0;
      over_q     <= 1'b0;
      ref_q      <= '0;
      digit_q    <= '0;
      an_q       <= 4'b1110;
      seg_q      <= 7'b1000000;
      dp_q       <= 1'b1;
    end else begin
      miss_l_q   <= bus.miss_left;
      miss_r_q   <= bus.miss_right;
      vblank_q   <= bus.vblank;
      new_game_q <= bus.new_game;
      armed_q    <= 1'b1;
      state_q    <= state_d;
      frame_q    <= frame_d;
      score_l_q  <= score_l_d;
      score_r_q  <= score_r_d;
      serve_q    <= serve_d;
      dir_q      <= dir_d;
      over_q     <= over_d;
      ref_q      <= ref_d;
      digit_q    <= digit_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign bus.score_left  = score_l_q;
  assign bus.score_right = score_r_q;
  assign bus.serve       = serve_q;
  assign bus.serve_dir   = dir_q;
  assign bus.game_over   = over_q;
  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter WIN_SCORE, default 9, is the points (1..9) that end a game.
REQ-002 Parameter SERVE_DELAY, default 120, is the vblank frames waited before each serve (1..255).
REQ-003 Parameter REFRESH_DIV, default 50000, is the clk cycles per display digit slot (>=2).
REQ-004 clk  in  1  system clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 miss_left  in  1  level; high while the ball is past the left paddle (point to right).
REQ-007 miss_right  in  1  level; high while the ball is past the right paddle (point to left).
REQ-008 vblank  in  1  level; the rising edge marks one frame.
REQ-009 new_game  in  1  level button; a rising edge restarts the game.
REQ-010 score_left  out  4  left player points, binary 0..WIN_SCORE.
REQ-011 score_right  out  4  right player points, binary 0..WIN_SCORE.
REQ-012 serve  out  1  one-cycle pulse that launches the ball.
REQ-013 serve_dir  out  1  launch direction for serve; 0 = rightwards, 1 = leftwards.
REQ-014 game_over  out  1  high while in GAME_OVER.
REQ-015 an  out  4  seven-segment anode selects, active-low, one-hot.
REQ-016 seg  out  7  segments, active-low; seg[0]=a ... seg[6]=g.
REQ-017 dp  out  1  decimal point, active-low.

Function
REQ-018 The block SHALL rising-edge-detect miss_left, miss_right, vblank and new_game using a one-cycle registered copy of each; only these edges act.
REQ-019 The FSM SHALL have three states: SERVE, PLAY and GAME_OVER.
REQ-020 SERVE behaviour:
- The frame counter SHALL increment on each vblank edge.
- On the edge that makes the count equal SERVE_DELAY, serve SHALL pulse for one cycle, and the FSM SHALL go to PLAY with the counter cleared.
REQ-021 PLAY, miss_left edge alone:
- score_right SHALL increment and serve_dir SHALL be set to 0.
- If the new score equals WIN_SCORE, the FSM SHALL go to GAME_OVER; otherwise it SHALL go to SERVE.
REQ-022 PLAY, miss_right edge alone: the same as REQ-021 with score_left incremented and serve_dir set to 1.
REQ-023 Simultaneous miss_left and miss_right edges in PLAY SHALL score nothing, keep serve_dir unchanged and go to SERVE.
REQ-024 Miss edges in SERVE or GAME_OVER SHALL be ignored.
REQ-025 A new_game edge in any state SHALL clear both scores and the frame counter, set serve_dir to 0 and go to SERVE. It takes priority over a miss edge in the same cycle.
REQ-026 Scores SHALL never exceed WIN_SCORE and SHALL never wrap.
REQ-027 The display refresh counter SHALL count 0..REFRESH_DIV-1 and wrap. On each wrap, the digit index SHALL advance 0->1->2->3->0.
REQ-028 The digit index SHALL drive an as follows: index k drives an[k] low and all other anodes high.
REQ-029 Digit contents:
- digit 3 shows score_left.
- digit 0 shows score_right.
- digits 1 and 2 show "-" (seg = 7'b0111111).
REQ-030 Segment decode SHALL be standard for 0..9 (for example, 0 = 7'b1000000 and 8 = 7'b0000000). Values 10..15 SHALL blank (7'b1111111).
REQ-031 dp SHALL be low only when game_over=1 and the winning side's digit (3 for left, 0 for right) is selected; otherwise it SHALL be high.
REQ-032 All outputs SHALL be registered; seg, an and dp SHALL change together in the same cycle.

Reset
REQ-033 While rst_n=0, the following SHALL hold asynchronously:
- FSM in SERVE; frame and refresh counters at 0; digit index 0.
- Scores 0; serve 0; serve_dir 0; game_over 0.
- an = 4'b1110; seg = 7'b1000000; dp = 1.
- Edge-detect registers 0.
REQ-034 Reset deassertion mid-frame SHALL start the serve count from 0. A vblank that is already high at release SHALL NOT count as an edge.

Verification
REQ-035 Power-up serve (SERVE_DELAY=3): release reset, then apply 3 vblank pulses -> one serve pulse on the 3rd edge, serve_dir=0, FSM in PLAY.
REQ-036 Scoring and hold: in PLAY, hold miss_left high for 50 cycles -> score_right=1 (not 50), serve_dir=0, FSM in SERVE; a further miss_right during SERVE -> no change.
REQ-037 Game end (WIN_SCORE=2): two miss_right points -> score_left=2, game_over=1; later misses are ignored; dp is low only in the an=4'b0111 slot.
REQ-038 Simultaneous misses: miss_left and miss_right rise in the same PLAY cycle -> scores unchanged, FSM in SERVE.
REQ-039 Display scan (REFRESH_DIV=4): an cycles 1110,1101,1011,0111 every 4 clocks; with score_left=3 and score_right=7, seg reads 7'b1111000, 7'b0111111, 7'b0111111, 7'b0110000 in that order.
REQ-040 Restart: a new_game edge coinciding with a miss edge in GAME_OVER, and reset asserted mid-SERVE, each return to scores 0, game_over=0 and serve count 0.
